// File: rtl/radar_pulse_sequencer.sv
// Per-PRI timing controller: drives awg_init / awg_enable / adc_enable for a programmed
// or continuous train of pulses, with configuration checking and graceful stop.
module radar_pulse_sequencer #(
    parameter int CNT_WIDTH = 32,
    parameter int GUARD     = 96
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 stop,
    input  logic [CNT_WIDTH-1:0] num_pulses,
    input  logic [CNT_WIDTH-1:0] prf_period,
    input  logic [CNT_WIDTH-1:0] awg_len,
    input  logic [CNT_WIDTH-1:0] adc_delay,
    input  logic [CNT_WIDTH-1:0] adc_len,
    output logic                 awg_init,
    output logic                 awg_enable,
    output logic                 adc_enable,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_error,
    output logic [CNT_WIDTH-1:0] pulse_count
);

    localparam int EW = CNT_WIDTH + 2;
    localparam logic [EW-1:0] GUARD_E = EW'(GUARD);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] t_q, t_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] num_q, num_d;
    logic [CNT_WIDTH-1:0] prf_q, prf_d;
    logic [CNT_WIDTH-1:0] awg_len_q, awg_len_d;
    logic [CNT_WIDTH-1:0] adc_dly_q, adc_dly_d;
    logic [CNT_WIDTH-1:0] adc_len_q, adc_len_d;
    logic                 stop_pend_q, stop_pend_d;
    logic                 bad_q, bad_d;
    logic                 awg_init_q, awg_init_d;
    logic                 awg_en_q, awg_en_d;
    logic                 adc_en_q, adc_en_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 cfg_error_q, cfg_error_d;
    logic                 cfg_ok;
    logic                 in_run;
    logic                 last_t;
    logic [CNT_WIDTH-1:0] cnt_inc;

    function automatic logic [EW-1:0] ext(input logic [CNT_WIDTH-1:0] v);
        return {2'b00, v};
    endfunction

    // Sums are formed two bits wider than the fields so no legal input can wrap.
    function automatic logic cfg_valid(
        input logic [CNT_WIDTH-1:0] prf,
        input logic [CNT_WIDTH-1:0] awg,
        input logic [CNT_WIDTH-1:0] dly,
        input logic [CNT_WIDTH-1:0] len
    );
        return (ext(prf) >= EW'(2))
            && (ext(awg) + EW'(1) <= ext(prf))
            && (ext(dly) >= EW'(1))
            && (ext(len) >= EW'(1))
            && (ext(dly) + ext(len) + GUARD_E <= ext(prf));
    endfunction

    function automatic logic in_adc_window(
        input logic [CNT_WIDTH-1:0] t,
        input logic [CNT_WIDTH-1:0] dly,
        input logic [CNT_WIDTH-1:0] len
    );
        return (ext(t) >= ext(dly)) && (ext(t) < ext(dly) + ext(len));
    endfunction

    assign cfg_ok  = cfg_valid(prf_q, awg_len_q, adc_dly_q, adc_len_q);
    assign in_run  = (state_q == S_RUN);
    assign last_t  = (t_q == prf_q - CNT_WIDTH'(1));
    assign cnt_inc = cnt_q + CNT_WIDTH'(1);

    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        cnt_d       = cnt_q;
        num_d       = num_q;
        prf_d       = prf_q;
        awg_len_d   = awg_len_q;
        adc_dly_d   = adc_dly_q;
        adc_len_d   = adc_len_q;
        stop_pend_d = stop_pend_q;
        bad_d       = 1'b0;

        // Strobes are registered decodes of the previous cycle's state and t.
        awg_init_d  = in_run && (t_q == '0);
        awg_en_d    = in_run && (t_q >= CNT_WIDTH'(1)) && (t_q <= awg_len_q);
        adc_en_d    = in_run && in_adc_window(t_q, adc_dly_q, adc_len_q);
        busy_d      = ((state_q == S_ARM) && cfg_ok) || in_run;
        done_d      = (state_q == S_DONE);
        cfg_error_d = bad_q;

        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    num_d     = num_pulses;
                    prf_d     = prf_period;
                    awg_len_d = awg_len;
                    adc_dly_d = adc_delay;
                    adc_len_d = adc_len;
                    state_d   = S_ARM;
                end
            end
            S_ARM: begin
                if (cfg_ok) begin
                    cnt_d       = '0;
                    t_d         = '0;
                    stop_pend_d = stop;
                    state_d     = S_RUN;
                end else begin
                    bad_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (last_t) begin
                    cnt_d = cnt_inc;
                    if (stop_pend_q || ((num_q != '0) && (cnt_inc == num_q))) begin
                        state_d = S_DONE;
                    end else begin
                        t_d = '0;
                    end
                end else begin
                    t_d = t_q + CNT_WIDTH'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            t_q         <= '0;
            cnt_q       <= '0;
            num_q       <= '0;
            prf_q       <= '0;
            awg_len_q   <= '0;
            adc_dly_q   <= '0;
            adc_len_q   <= '0;
            stop_pend_q <= 1'b0;
            bad_q       <= 1'b0;
            awg_init_q  <= 1'b0;
            awg_en_q    <= 1'b0;
            adc_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            cnt_q       <= cnt_d;
            num_q       <= num_d;
            prf_q       <= prf_d;
            awg_len_q   <= awg_len_d;
            adc_dly_q   <= adc_dly_d;
            adc_len_q   <= adc_len_d;
            stop_pend_q <= stop_pend_d;
            bad_q       <= bad_d;
            awg_init_q  <= awg_init_d;
            awg_en_q    <= awg_en_d;
            adc_en_q    <= adc_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_error_q <= cfg_error_d;
        end
    end

    assign awg_init    = awg_init_q;
    assign awg_enable  = awg_en_q;
    assign adc_enable  = adc_en_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cfg_error   = cfg_error_q;
    assign pulse_count = cnt_q;

endmodule

// File: tb/tb_radar_pulse_sequencer.sv
// Directed bench for radar_pulse_sequencer: expected strobe vectors are queued when a run
// is launched and popped one per cycle against the DUT outputs.
module tb_radar_pulse_sequencer;

    localparam int CW    = 32;
    localparam int GUARD = 96;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic          stop;
    logic [CW-1:0] num_pulses;
    logic [CW-1:0] prf_period;
    logic [CW-1:0] awg_len;
    logic [CW-1:0] adc_delay;
    logic [CW-1:0] adc_len;
    logic          awg_init;
    logic          awg_enable;
    logic          adc_enable;
    logic          busy;
    logic          done;
    logic          cfg_error;
    logic [CW-1:0] pulse_count;

    radar_pulse_sequencer #(.CNT_WIDTH(CW), .GUARD(GUARD)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .stop       (stop),
        .num_pulses (num_pulses),
        .prf_period (prf_period),
        .awg_len    (awg_len),
        .adc_delay  (adc_delay),
        .adc_len    (adc_len),
        .awg_init   (awg_init),
        .awg_enable (awg_enable),
        .adc_enable (adc_enable),
        .busy       (busy),
        .done       (done),
        .cfg_error  (cfg_error),
        .pulse_count(pulse_count)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    logic [5:0] exp_q[$];
    int         c_np, c_prf, c_awg, c_dly, c_len;
    int         gap;

    // Output vector order: {awg_init, awg_enable, adc_enable, busy, done, cfg_error}
    function automatic logic [5:0] obs();
        return {awg_init, awg_enable, adc_enable, busy, done, cfg_error};
    endfunction

    // k counts cycles after the edge that samples start; RUN outputs begin at k=2.
    function automatic logic [5:0] exp_vec(input int k, input int n, input int prf,
                                           input int awg, input int dly, input int len,
                                           input bit rej);
        int   r;
        int   t;
        logic ai, ae, de, b, d;
        ai = 1'b0; ae = 1'b0; de = 1'b0;
        if (rej) return (k == 2) ? 6'b000001 : 6'b000000;
        r = k - 2;
        b = (k >= 1) && (k <= 1 + n * prf);
        d = (k == 2 + n * prf);
        if (r >= 0 && r < n * prf) begin
            t  = r % prf;
            ai = (t == 0);
            ae = (t >= 1) && (t <= awg);
            de = (t >= dly) && (t < dly + len);
        end
        return {ai, ae, de, b, d, 1'b0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        assert (got === expv)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, expv);
        end
    endtask

    task automatic run_case(input string name, input int n_exp, input bit rej,
                            input int kmax, input int start_k, input int stop_k,
                            input int rst_k, output int gap_o);
        int         last_adc;
        int         inits;
        logic [5:0] e;
        gap_o    = -1;
        last_adc = -1;
        inits    = 0;
        num_pulses = c_np;
        prf_period = c_prf;
        awg_len    = c_awg;
        adc_delay  = c_dly;
        adc_len    = c_len;
        stop  = 1'b0;
        start = 1'b1;
        for (int k = 1; k <= kmax; k++) begin
            exp_q.push_back(exp_vec(k, n_exp, c_prf, c_awg, c_dly, c_len, rej));
        end
        tick();
        start      = 1'b0;
        num_pulses = 1;
        prf_period = 7;
        awg_len    = 3;
        adc_delay  = 0;
        adc_len    = 0;
        for (int k = 1; k <= kmax; k++) begin
            tick();
            e = exp_q.pop_front();
            chk($sformatf("%s_k%0d", name, k), {58'd0, obs()}, {58'd0, e});
            if (e[1]) chk({name, "_count"}, {32'd0, pulse_count}, n_exp);
            if (awg_init) begin
                inits++;
                if (inits == 2 && last_adc >= 0) gap_o = k - last_adc - 1;
            end
            if (adc_enable) last_adc = k;
            start = (k == start_k);
            stop  = (k == stop_k);
            if (k == rst_k) begin
                resetn = 1'b0;
                #1;
                chk({name, "_rst_outs"}, {58'd0, obs()}, 64'd0);
                chk({name, "_rst_count"}, {32'd0, pulse_count}, 64'd0);
                exp_q.delete();
                break;
            end
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        start  = 1'b0;
        stop   = 1'b0;
        num_pulses = '0;
        prf_period = '0;
        awg_len    = '0;
        adc_delay  = '0;
        adc_len    = '0;
        repeat (3) tick();
        chk("reset_outs", {58'd0, obs()}, 64'd0);
        chk("reset_count", {32'd0, pulse_count}, 64'd0);
        resetn = 1'b1;
        tick();
        chk("idle_outs", {58'd0, obs()}, 64'd0);

        // Finite run of two pulses, with a stray start mid-run
        c_np = 2; c_prf = 200; c_awg = 50; c_dly = 10; c_len = 80;
        run_case("finite", 2, 1'b0, 403, 50, 0, 0, gap);
        tick();
        chk("finite_count_after", {32'd0, pulse_count}, 64'd2);
        chk("finite_busy_after", {63'd0, busy}, 64'd0);

        // 10 + 100 + 96 > 200 must be rejected without touching pulse_count
        c_np = 1; c_prf = 200; c_awg = 50; c_dly = 10; c_len = 100;
        run_case("reject", 0, 1'b1, 8, 0, 0, 0, gap);
        chk("reject_count", {32'd0, pulse_count}, 64'd2);

        // start and stop together in IDLE
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("startstop_outs%0d", i), {58'd0, obs()}, 64'd0);
        end
        chk("startstop_count", {32'd0, pulse_count}, 64'd2);

        // Continuous mode, stop raised at t=20 of the third PRI (k = 2 + 300 + 20)
        c_np = 0; c_prf = 150; c_awg = 30; c_dly = 5; c_len = 40;
        run_case("cont", 3, 1'b0, 453, 0, 322, 0, gap);

        // Exact guard fit, AWG disabled
        c_np = 2; c_prf = 200; c_awg = 0; c_dly = 50; c_len = 54;
        run_case("guard", 2, 1'b0, 403, 0, 0, 0, gap);
        chk("guard_gap", gap, GUARD);

        // Asynchronous reset at t=60 of the first PRI
        c_np = 3; c_prf = 200; c_awg = 100; c_dly = 10; c_len = 80;
        run_case("arst", 3, 1'b0, 600, 0, 0, 62, gap);
        tick();
        tick();
        resetn = 1'b1;
        tick();
        chk("arst_idle_outs", {58'd0, obs()}, 64'd0);
        chk("arst_idle_count", {32'd0, pulse_count}, 64'd0);

        c_np = 1; c_prf = 200; c_awg = 50; c_dly = 10; c_len = 80;
        run_case("fresh", 1, 1'b0, 203, 0, 0, 0, gap);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
